// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator.
package pwm_pkg;

  // Default width of period, duty, prescaler and all internal counters.
  localparam int unsigned PWM_W = 16;

endpackage : pwm_pkg

// File: rtl/pwm_prescaler.sv
// Clock prescaler: emits a one-cycle tick (clk_div) every presc_eff clocks while enabled.
// presc_eff must be at least 1; the caller clamps a programmed 0 up to 1.
module pwm_prescaler
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH = PWM_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] presc_eff,
  output logic             clk_div,
  output logic [WIDTH-1:0] pcnt
);

  // >= rather than == so a prescaler that shrinks below pcnt ticks at once instead of
  // running the count all the way around.
  always_comb begin
    clk_div = enable && (pcnt >= (presc_eff - WIDTH'(1)));
  end

  // Prescale count: cleared by reset, while disabled and on every tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt <= '0;
    end else if (!enable || clk_div) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + WIDTH'(1);
    end
  end

endmodule : pwm_prescaler

// File: rtl/pwm_core.sv
// PWM generator with programmable period, duty cycle and clock prescaler.
// Optional build macro PWM_CORE_SHADOW_EN: when defined, period/duty/prescaler are captured
// in shadow registers that update only at the period wrap, under reset or while disabled,
// giving glitch-free reprogramming. When undefined the inputs are used live every cycle.
module pwm_core
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH = PWM_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] period,
  input  logic [WIDTH-1:0] duty_cycle,
  input  logic [WIDTH-1:0] prescaler,
  input  logic             enable,
  output logic             pwm_out
);

  logic [WIDTH-1:0] period_sh;
  logic [WIDTH-1:0] duty_sh;
  logic [WIDTH-1:0] presc_sh;
  logic [WIDTH-1:0] presc_eff;
  logic [WIDTH-1:0] period_minus_1;
  logic [WIDTH-1:0] counter;
  logic [WIDTH-1:0] pcnt;
  logic             clk_div;
  logic             wrap;

  // Derived period terms; period_minus_1 wraps to all-ones for a zero period, which is why
  // a zero period forces the wrap explicitly.
  always_comb begin
    presc_eff      = (presc_sh == '0) ? WIDTH'(1) : presc_sh;
    period_minus_1 = period_sh - WIDTH'(1);
    wrap           = (period_sh == '0) || (counter >= period_minus_1);
  end

`ifdef PWM_CORE_SHADOW_EN
  // Shadow settings: load under reset, while disabled and at the period boundary.
  always_ff @(posedge clk) begin
    if (reset || !enable || (clk_div && wrap)) begin
      period_sh <= period;
      duty_sh   <= duty_cycle;
      presc_sh  <= prescaler;
    end
  end
`else
  // Shadows bypassed: settings take effect on the next clock.
  always_comb begin
    period_sh = period;
    duty_sh   = duty_cycle;
    presc_sh  = prescaler;
  end
`endif

  pwm_prescaler #(
    .WIDTH (WIDTH)
  ) u_prescaler (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .presc_eff (presc_eff),
    .clk_div   (clk_div),
    .pcnt      (pcnt)
  );

  // Period counter advances once per tick and returns to 0 at the wrap.
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      counter <= '0;
    end else if (clk_div) begin
      counter <= wrap ? '0 : counter + WIDTH'(1);
    end
  end

  // Registered compare: one clock of latency from counter to pin.
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      pwm_out <= 1'b0;
    end else begin
      pwm_out <= (period_sh != '0) && (counter < duty_sh);
    end
  end

endmodule : pwm_core

// File: tb/tb_pwm_core.sv
// Directed self-checking bench for pwm_core. Edge k (k >= 1) is the k-th enabled rising edge
// after a restart from counter 0; pwm_out sampled 1 ns after edge k is expected high when
// floor((k-1)/presc) mod period < duty.
module tb_pwm_core;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] period;
  logic [15:0] duty_cycle;
  logic [15:0] prescaler;
  logic        pwm_out;

  int checks = 0;
  int passed = 0;

  pwm_core #(
    .WIDTH (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .period     (period),
    .duty_cycle (duty_cycle),
    .prescaler  (prescaler),
    .enable     (enable),
    .pwm_out    (pwm_out)
  );

  always #5 clk = ~clk;

  function automatic logic exp_pwm(int k, int p_len, int duty, int presc);
    int pe;
    pe = (presc < 1) ? 1 : presc;
    if (p_len == 0 || k < 1) return 1'b0;
    return (((k - 1) / pe) % p_len) < duty;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One disabled edge loads the new settings and parks the counters at 0.
  task automatic restart(input int p_len, input int duty, input int presc);
    enable     = 1'b0;
    period     = 16'(p_len);
    duty_cycle = 16'(duty);
    prescaler  = 16'(presc);
    tick();
    enable = 1'b1;
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    enable     = 1'b1;
    period     = 16'd100;
    duty_cycle = 16'd50;
    prescaler  = 16'd1;
    repeat (10) tick();
    checks++;
    if (pwm_out !== 1'b0) $display("FAIL reset_pwm: got %0b want 0", pwm_out);
    else passed++;
    checks++;
    if (dut.counter !== 16'd0) $display("FAIL reset_counter: got %0d want 0", dut.counter);
    else passed++;
    checks++;
    if (dut.u_prescaler.pcnt !== 16'd0)
      $display("FAIL reset_pcnt: got %0d want 0", dut.u_prescaler.pcnt);
    else passed++;
    checks++;
    if (dut.period_minus_1 !== 16'd99)
      $display("FAIL reset_pm1: got %0d want 99", dut.period_minus_1);
    else passed++;
  endtask

  // Runs straight on from reset release: period 100, duty 50, one tick per clock.
  task automatic test_basic();
    int highs;
    highs = 0;
    reset = 1'b0;
    for (int k = 1; k <= 2000; k++) begin
      tick();
      if (k <= 1000 && pwm_out === 1'b1) highs++;
      checks++;
      if (pwm_out !== exp_pwm(k, 100, 50, 1))
        $display("FAIL basic_pwm k=%0d: got %0b want %0b", k, pwm_out, exp_pwm(k, 100, 50, 1));
      else passed++;
      checks++;
      if (dut.counter !== 16'(k % 100))
        $display("FAIL basic_counter k=%0d: got %0d want %0d", k, dut.counter, k % 100);
      else passed++;
    end
    checks++;
    if (highs != 500) $display("FAIL basic_high_time: got %0d want 500", highs);
    else passed++;
  endtask

  // Duty raised to 75 while the counter is at 30.
  task automatic test_duty_change();
    int dk;
    int highs;
    highs = 0;
    restart(100, 50, 1);
    for (int k = 1; k <= 300; k++) begin
      tick();
`ifdef PWM_CORE_SHADOW_EN
      dk = (k <= 100) ? 50 : 75;
`else
      dk = (k <= 30) ? 50 : 75;
`endif
      if (k > 200 && pwm_out === 1'b1) highs++;
      checks++;
      if (pwm_out !== exp_pwm(k, 100, dk, 1))
        $display("FAIL duty_change_pwm k=%0d: got %0b want %0b", k, pwm_out,
                 exp_pwm(k, 100, dk, 1));
      else passed++;
      if (k == 30) duty_cycle = 16'd75;
    end
    checks++;
    if (highs != 75) $display("FAIL duty_change_high_time: got %0d want 75", highs);
    else passed++;
  endtask

  task automatic test_period_change();
    restart(200, 75, 1);
    checks++;
    if (dut.period_minus_1 !== 16'd199)
      $display("FAIL period_pm1: got %0d want 199", dut.period_minus_1);
    else passed++;
    for (int k = 1; k <= 400; k++) begin
      tick();
      checks++;
      if (pwm_out !== exp_pwm(k, 200, 75, 1))
        $display("FAIL period_pwm k=%0d: got %0b want %0b", k, pwm_out, exp_pwm(k, 200, 75, 1));
      else passed++;
    end
  endtask

  task automatic test_prescaler();
    for (int p = 2; p <= 3; p++) begin
      restart(20, 7, p);
      for (int k = 1; k <= 40 * p; k++) begin
        tick();
        checks++;
        if (pwm_out !== exp_pwm(k, 20, 7, p))
          $display("FAIL presc%0d_pwm k=%0d: got %0b want %0b", p, k, pwm_out,
                   exp_pwm(k, 20, 7, p));
        else passed++;
        checks++;
        if (dut.clk_div !== ((k % p) == p - 1))
          $display("FAIL presc%0d_tick k=%0d: got %0b want %0b", p, k, dut.clk_div,
                   ((k % p) == p - 1));
        else passed++;
        checks++;
        if (dut.counter !== 16'((k / p) % 20))
          $display("FAIL presc%0d_counter k=%0d: got %0d want %0d", p, k, dut.counter,
                   (k / p) % 20);
        else passed++;
      end
    end
    // Prescaler 0 behaves as 1.
    restart(10, 3, 0);
    for (int k = 1; k <= 30; k++) begin
      tick();
      checks++;
      if (pwm_out !== exp_pwm(k, 10, 3, 1))
        $display("FAIL presc0_pwm k=%0d: got %0b want %0b", k, pwm_out, exp_pwm(k, 10, 3, 1));
      else passed++;
    end
  endtask

  // Reset asserted mid-run with enable still high.
  task automatic test_reset_mid();
    restart(10, 4, 1);
    repeat (13) tick();
    reset = 1'b1;
    tick();
    checks++;
    if (pwm_out !== 1'b0 || dut.counter !== 16'd0)
      $display("FAIL reset_mid_first: got pwm=%0b cnt=%0d want pwm=0 cnt=0", pwm_out, dut.counter);
    else passed++;
    repeat (9) tick();
    checks++;
    if (pwm_out !== 1'b0 || dut.counter !== 16'd0)
      $display("FAIL reset_mid_hold: got pwm=%0b cnt=%0d want pwm=0 cnt=0", pwm_out, dut.counter);
    else passed++;
    reset = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      checks++;
      if (pwm_out !== exp_pwm(k, 10, 4, 1))
        $display("FAIL reset_mid_pwm k=%0d: got %0b want %0b", k, pwm_out, exp_pwm(k, 10, 4, 1));
      else passed++;
    end
  endtask

  task automatic test_disable();
    restart(10, 4, 1);
    repeat (2) tick();
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (pwm_out !== 1'b0 || dut.counter !== 16'd0)
        $display("FAIL disable_hold i=%0d: got pwm=%0b cnt=%0d want pwm=0 cnt=0", i, pwm_out,
                 dut.counter);
      else passed++;
    end
    enable = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      checks++;
      if (pwm_out !== exp_pwm(k, 10, 4, 1))
        $display("FAIL disable_restart k=%0d: got %0b want %0b", k, pwm_out, exp_pwm(k, 10, 4, 1));
      else passed++;
    end
  endtask

  task automatic test_corners();
    int cp[6] = '{10, 10, 10, 0, 1, 1};
    int cd[6] = '{0, 10, 15, 5, 1, 0};
    for (int c = 0; c < 6; c++) begin
      restart(cp[c], cd[c], 1);
      for (int k = 1; k <= 25; k++) begin
        tick();
        checks++;
        if (pwm_out !== exp_pwm(k, cp[c], cd[c], 1))
          $display("FAIL corner P=%0d D=%0d k=%0d: got %0b want %0b", cp[c], cd[c], k, pwm_out,
                   exp_pwm(k, cp[c], cd[c], 1));
        else passed++;
        if (cp[c] <= 1) begin
          checks++;
          if (dut.counter !== 16'd0)
            $display("FAIL corner_counter P=%0d k=%0d: got %0d want 0", cp[c], k, dut.counter);
          else passed++;
        end
      end
    end
  endtask

  // A zero period reloads every tick, so a new period starts without disabling.
  task automatic test_zero_period_recover();
    int off;
`ifdef PWM_CORE_SHADOW_EN
    off = 1;
`else
    off = 0;
`endif
    restart(0, 3, 1);
    repeat (5) tick();
    period = 16'd10;
    for (int j = 1; j <= 30; j++) begin
      tick();
      checks++;
      if (pwm_out !== exp_pwm(j - off, 10, 3, 1))
        $display("FAIL zero_period_recover j=%0d: got %0b want %0b", j, pwm_out,
                 exp_pwm(j - off, 10, 3, 1));
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_duty_change();
    test_period_change();
    test_prescaler();
    test_reset_mid();
    test_disable();
    test_corners();
    test_zero_period_recover();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule : tb_pwm_core
